// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: register-file sizing, ALU opcodes, issue FSM states and
// the per-slot register-usage record consumed by hazard checks.
package riscv_pkg;

  localparam int unsigned NUM_A_REGS   = 32;
  localparam int unsigned REG_IDX_SIZE = $clog2(NUM_A_REGS);

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl,
    AluSra,
    AluSlt,
    AluSltu,
    AluLui
  } alu_op_t;

  typedef enum logic [0:0] {
    PAIR,
    HOLD1
  } issue_state_t;

  typedef struct packed {
    logic [REG_IDX_SIZE-1:0] rd;
    logic [REG_IDX_SIZE-1:0] rs1;
    logic [REG_IDX_SIZE-1:0] rs2;
    logic                    we;
    logic                    use_rs1;
    logic                    use_rs2;
  } slot_regs_t;

  // True when the slot actually reads register r through either source port.
  function automatic logic slot_reads(slot_regs_t s, logic [REG_IDX_SIZE-1:0] r);
    return (s.use_rs1 && (s.rs1 == r)) || (s.use_rs2 && (s.rs2 == r));
  endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational check: does the younger slot depend on the older slot's destination
// (RAW through rs1/rs2, or WAW)? Writes to x0 never create a dependency.
module pair_hazard_check
  import riscv_pkg::*;
(
  input  slot_regs_t older_i,
  input  slot_regs_t younger_i,
  output logic       dep_o
);

  logic older_writes;
  logic raw;
  logic waw;

  always_comb begin
    older_writes = older_i.we && (older_i.rd != '0);
    raw          = slot_reads(younger_i, older_i.rd);
    waw          = younger_i.we && (younger_i.rd == older_i.rd);
    dep_o        = older_writes && (raw || waw);
  end

endmodule

// File: rtl/dual_issue_controller.sv
// Pair issue controller: issues the decoded pair together, or splits it over two
// cycles when slot 1 depends on slot 0, and counts issued instructions and splits.
module dual_issue_controller #(
  parameter int unsigned NUM_A_REGS = riscv_pkg::NUM_A_REGS,
  parameter int unsigned CNT_SIZE   = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          pair_valid_i,
  input  logic                          valid0_i,
  input  logic                          valid1_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] rd0_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] rs10_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] rs20_i,
  input  logic                          we0_i,
  input  logic                          use_rs10_i,
  input  logic                          use_rs20_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] rd1_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] rs11_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] rs21_i,
  input  logic                          we1_i,
  input  logic                          use_rs11_i,
  input  logic                          use_rs21_i,
  input  logic                          ex_ready_i,
  input  logic                          flush_i,
  output logic                          pair_ready_o,
  output logic                          lane0_valid_o,
  output logic                          lane0_sel_o,
  output logic                          lane1_valid_o,
  output logic [CNT_SIZE-1:0]           issue_cnt_o,
  output logic [CNT_SIZE-1:0]           split_cnt_o
);

  import riscv_pkg::slot_regs_t;
  import riscv_pkg::issue_state_t;
  import riscv_pkg::PAIR;
  import riscv_pkg::HOLD1;

  localparam int unsigned PkgIdxW = riscv_pkg::REG_IDX_SIZE;

  slot_regs_t   slot0;
  slot_regs_t   slot1;
  logic         dep;

  issue_state_t state_q, state_d;
  logic [CNT_SIZE-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_SIZE-1:0] split_cnt_q, split_cnt_d;
  logic [1:0]          issue_inc;
  logic                split_inc;

  always_comb begin
    slot0.rd      = PkgIdxW'(rd0_i);
    slot0.rs1     = PkgIdxW'(rs10_i);
    slot0.rs2     = PkgIdxW'(rs20_i);
    slot0.we      = we0_i;
    slot0.use_rs1 = use_rs10_i;
    slot0.use_rs2 = use_rs20_i;
    slot1.rd      = PkgIdxW'(rd1_i);
    slot1.rs1     = PkgIdxW'(rs11_i);
    slot1.rs2     = PkgIdxW'(rs21_i);
    slot1.we      = we1_i;
    slot1.use_rs1 = use_rs11_i;
    slot1.use_rs2 = use_rs21_i;
  end

  pair_hazard_check u_hazard (
    .older_i   (slot0),
    .younger_i (slot1),
    .dep_o     (dep)
  );

  always_comb begin
    state_d       = state_q;
    issue_inc     = 2'd0;
    split_inc     = 1'b0;
    pair_ready_o  = 1'b0;
    lane0_valid_o = 1'b0;
    lane0_sel_o   = 1'b0;
    lane1_valid_o = 1'b0;

    // Outputs are held low for as long as reset is asserted.
    if (!rst_ni) begin
      state_d = PAIR;
    end else if (flush_i) begin
      pair_ready_o = 1'b1;
      state_d      = PAIR;
    end else if (ex_ready_i) begin
      unique case (state_q)
        PAIR: begin
          if (pair_valid_i) begin
            if (valid0_i && valid1_i) begin
              lane0_valid_o = 1'b1;
              if (dep) begin
                issue_inc = 2'd1;
                split_inc = 1'b1;
                state_d   = HOLD1;
              end else begin
                lane1_valid_o = 1'b1;
                pair_ready_o  = 1'b1;
                issue_inc     = 2'd2;
              end
            end else if (valid0_i || valid1_i) begin
              lane0_valid_o = 1'b1;
              lane0_sel_o   = valid1_i;
              pair_ready_o  = 1'b1;
              issue_inc     = 2'd1;
            end else begin
              pair_ready_o = 1'b1;
            end
          end
        end
        HOLD1: begin
          lane0_valid_o = 1'b1;
          lane0_sel_o   = 1'b1;
          pair_ready_o  = 1'b1;
          issue_inc     = 2'd1;
          state_d       = PAIR;
        end
        default: state_d = PAIR;
      endcase
    end

    issue_cnt_d = issue_cnt_q + CNT_SIZE'(issue_inc);
    split_cnt_d = split_cnt_q + CNT_SIZE'(split_inc);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= PAIR;
      issue_cnt_q <= '0;
      split_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign issue_cnt_o = issue_cnt_q;
  assign split_cnt_o = split_cnt_q;

endmodule

// File: tb/tb_dual_issue_controller.sv
// Bench for dual_issue_controller: vector table, directed multi-cycle sequences and
// randomized traffic against a rule-level reference model.
module tb_dual_issue_controller;

  typedef struct {
    logic       pv, v0, v1;
    logic [4:0] rd0, rs10, rs20;
    logic       we0, u10, u20;
    logic [4:0] rd1, rs11, rs21;
    logic       we1, u11, u21;
    logic       exr, fl;
  } in_t;

  typedef struct {
    in_t  in;
    logic pr, l0, sel, l1;
    int   di, ds;
    string nm;
  } vec_t;

  logic        clk, rst_n;
  logic        pair_valid, valid0, valid1;
  logic [4:0]  rd0, rs10, rs20, rd1, rs11, rs21;
  logic        we0, use_rs10, use_rs20, we1, use_rs11, use_rs21;
  logic        ex_ready, flush;
  logic        pair_ready, lane0_valid, lane0_sel, lane1_valid;
  logic [31:0] issue_cnt, split_cnt;

  int          total, bad;
  bit          m_hold;
  int unsigned m_issue, m_split;

  dual_issue_controller #(
    .NUM_A_REGS (32),
    .CNT_SIZE   (32)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pair_valid_i  (pair_valid),
    .valid0_i      (valid0),
    .valid1_i      (valid1),
    .rd0_i         (rd0),
    .rs10_i        (rs10),
    .rs20_i        (rs20),
    .we0_i         (we0),
    .use_rs10_i    (use_rs10),
    .use_rs20_i    (use_rs20),
    .rd1_i         (rd1),
    .rs11_i        (rs11),
    .rs21_i        (rs21),
    .we1_i         (we1),
    .use_rs11_i    (use_rs11),
    .use_rs21_i    (use_rs21),
    .ex_ready_i    (ex_ready),
    .flush_i       (flush),
    .pair_ready_o  (pair_ready),
    .lane0_valid_o (lane0_valid),
    .lane0_sel_o   (lane0_sel),
    .lane1_valid_o (lane1_valid),
    .issue_cnt_o   (issue_cnt),
    .split_cnt_o   (split_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input logic [4:0] a_rd, a_rs1, a_rs2, input logic a_we, a_u1, a_u2,
                             input logic [4:0] b_rd, b_rs1, b_rs2, input logic b_we, b_u1, b_u2);
    in_t s;
    s.pv = 1; s.v0 = 1; s.v1 = 1; s.exr = 1; s.fl = 0;
    s.rd0 = a_rd; s.rs10 = a_rs1; s.rs20 = a_rs2; s.we0 = a_we; s.u10 = a_u1; s.u20 = a_u2;
    s.rd1 = b_rd; s.rs11 = b_rs1; s.rs21 = b_rs2; s.we1 = b_we; s.u11 = b_u1; s.u21 = b_u2;
    return s;
  endfunction

  function automatic bit spec_dep(input in_t s);
    return s.we0 && (s.rd0 != 0) &&
           ((s.u11 && s.rs11 == s.rd0) || (s.u21 && s.rs21 == s.rd0) || (s.we1 && s.rd1 == s.rd0));
  endfunction

  // Reference: what the controller must do this cycle given whether an instruction is held.
  function automatic void model(input in_t s, input bit hold, output bit pr, l0, sel, l1,
                                output int di, ds, output bit nh);
    pr = 0; l0 = 0; sel = 0; l1 = 0; di = 0; ds = 0; nh = hold;
    if (s.fl) begin
      pr = 1; nh = 0;
    end else if (!s.exr) begin
      nh = hold;
    end else if (hold) begin
      l0 = 1; sel = 1; pr = 1; di = 1; nh = 0;
    end else if (s.pv) begin
      if (s.v0 && s.v1) begin
        l0 = 1;
        if (spec_dep(s)) begin
          di = 1; ds = 1; nh = 1;
        end else begin
          l1 = 1; pr = 1; di = 2;
        end
      end else if (s.v0 || s.v1) begin
        l0 = 1; sel = s.v1; pr = 1; di = 1;
      end else begin
        pr = 1;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t s);
    pair_valid = s.pv; valid0 = s.v0; valid1 = s.v1;
    rd0 = s.rd0; rs10 = s.rs10; rs20 = s.rs20; we0 = s.we0; use_rs10 = s.u10; use_rs20 = s.u20;
    rd1 = s.rd1; rs11 = s.rs11; rs21 = s.rs21; we1 = s.we1; use_rs11 = s.u11; use_rs21 = s.u21;
    ex_ready = s.exr; flush = s.fl;
  endtask

  task automatic check_outs(input string nm, input bit pr, l0, sel, l1);
    chk({nm, " pair_ready"}, {31'd0, pair_ready}, {31'd0, pr});
    chk({nm, " lane0_valid"}, {31'd0, lane0_valid}, {31'd0, l0});
    chk({nm, " lane0_sel"}, {31'd0, lane0_sel}, {31'd0, sel});
    chk({nm, " lane1_valid"}, {31'd0, lane1_valid}, {31'd0, l1});
    chk({nm, " issue_cnt"}, issue_cnt, m_issue);
    chk({nm, " split_cnt"}, split_cnt, m_split);
  endtask

  task automatic step(input in_t s, input string nm, output bit pr_out);
    bit pr, l0, sel, l1, nh;
    int di, ds;
    drive(s);
    #1;
    model(s, m_hold, pr, l0, sel, l1, di, ds, nh);
    check_outs(nm, pr, l0, sel, l1);
    @(posedge clk); #1;
    m_hold = nh; m_issue += di; m_split += ds;
    pr_out = pr;
  endtask

  task automatic do_reset(input in_t s);
    drive(s);
    rst_n = 0;
    #1;
    chk("reset pair_ready", {31'd0, pair_ready}, 32'd0);
    chk("reset lane0_valid", {31'd0, lane0_valid}, 32'd0);
    chk("reset lane0_sel", {31'd0, lane0_sel}, 32'd0);
    chk("reset lane1_valid", {31'd0, lane1_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    m_hold = 0; m_issue = 0; m_split = 0;
  endtask

  in_t  s, raw, ind, cur;
  vec_t tbl[14];
  bit   pr;

  initial begin
    total = 0; bad = 0;
    rst_n = 0;
    raw = mk(5, 1, 2, 1, 1, 1, 7, 5, 3, 1, 1, 1);  // add x5,x1,x2 ; sub x7,x5,x3
    ind = mk(1, 2, 3, 1, 1, 1, 4, 5, 6, 1, 1, 1);  // add x1,x2,x3 ; add x4,x5,x6
    drive(ind);
    @(posedge clk); #1;
    do_reset(raw);

    // Single-cycle vectors, each applied from PAIR state.
    tbl[0] = '{in: ind, pr: 1, l0: 1, sel: 0, l1: 1, di: 2, ds: 0, nm: "indep"};
    tbl[1] = '{in: raw, pr: 0, l0: 1, sel: 0, l1: 0, di: 1, ds: 1, nm: "raw_rs1"};
    s = mk(5, 1, 2, 1, 1, 1, 7, 3, 5, 1, 1, 1);
    tbl[2] = '{in: s, pr: 0, l0: 1, sel: 0, l1: 0, di: 1, ds: 1, nm: "raw_rs2"};
    s = mk(0, 1, 2, 1, 1, 1, 7, 0, 0, 1, 1, 1);
    tbl[3] = '{in: s, pr: 1, l0: 1, sel: 0, l1: 1, di: 2, ds: 0, nm: "rd0_x0"};
    s = mk(9, 1, 2, 1, 1, 1, 9, 3, 4, 1, 1, 1);
    tbl[4] = '{in: s, pr: 0, l0: 1, sel: 0, l1: 0, di: 1, ds: 1, nm: "waw"};
    s = raw; s.we0 = 0;
    tbl[5] = '{in: s, pr: 1, l0: 1, sel: 0, l1: 1, di: 2, ds: 0, nm: "no_we0"};
    s = mk(5, 1, 2, 1, 1, 1, 7, 5, 3, 0, 0, 1);
    tbl[6] = '{in: s, pr: 1, l0: 1, sel: 0, l1: 1, di: 2, ds: 0, nm: "unused_rs1"};
    s = raw; s.v1 = 0;
    tbl[7] = '{in: s, pr: 1, l0: 1, sel: 0, l1: 0, di: 1, ds: 0, nm: "only0"};
    s = raw; s.v0 = 0;
    tbl[8] = '{in: s, pr: 1, l0: 1, sel: 1, l1: 0, di: 1, ds: 0, nm: "only1"};
    s = raw; s.v0 = 0; s.v1 = 0;
    tbl[9] = '{in: s, pr: 1, l0: 0, sel: 0, l1: 0, di: 0, ds: 0, nm: "none_valid"};
    s = ind; s.pv = 0;
    tbl[10] = '{in: s, pr: 0, l0: 0, sel: 0, l1: 0, di: 0, ds: 0, nm: "no_pair"};
    s = ind; s.exr = 0;
    tbl[11] = '{in: s, pr: 0, l0: 0, sel: 0, l1: 0, di: 0, ds: 0, nm: "stall"};
    s = ind; s.fl = 1;
    tbl[12] = '{in: s, pr: 1, l0: 0, sel: 0, l1: 0, di: 0, ds: 0, nm: "flush"};
    s = mk(9, 1, 2, 1, 1, 1, 9, 3, 4, 0, 0, 0);
    tbl[13] = '{in: s, pr: 1, l0: 1, sel: 0, l1: 1, di: 2, ds: 0, nm: "rd_same_no_we1"};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].in);
      #1;
      check_outs(tbl[i].nm, tbl[i].pr, tbl[i].l0, tbl[i].sel, tbl[i].l1);
      @(posedge clk); #1;
      m_issue += tbl[i].di; m_split += tbl[i].ds;
      m_hold = tbl[i].l0 && !tbl[i].pr;
      s = tbl[i].in; s.exr = 0; s.fl = 1;
      step(s, "recover", pr);
    end

    // Backpressure on a RAW pair, then the split runs normally.
    do_reset(ind);
    s = raw; s.exr = 0;
    for (int i = 0; i < 3; i++) step(s, "bp_stall", pr);
    chk("bp issue_cnt hold", issue_cnt, 32'd0);
    s.exr = 1;
    step(s, "bp_split0", pr);
    step(s, "bp_split1", pr);
    chk("bp issue_cnt", issue_cnt, 32'd2);
    chk("bp split_cnt", split_cnt, 32'd1);

    // Flush in HOLD1 with ex_ready high; independent pair afterwards proves PAIR state.
    step(raw, "fh_split0", pr);
    s = raw; s.fl = 1;
    step(s, "fh_flush", pr);
    chk("fh issue_cnt", issue_cnt, 32'd3);
    step(ind, "fh_after", pr);

    // Reset while in HOLD1 with counters at 5/2.
    do_reset(ind);
    step(ind, "rh_indep", pr);
    step(raw, "rh_raw0", pr);
    step(raw, "rh_raw1", pr);
    step(raw, "rh_raw2", pr);
    chk("rh issue_cnt pre", issue_cnt, 32'd5);
    chk("rh split_cnt pre", split_cnt, 32'd2);
    do_reset(raw);
    chk("rh issue_cnt post", issue_cnt, 32'd0);
    chk("rh split_cnt post", split_cnt, 32'd0);
    s = raw; s.v1 = 0;
    step(s, "rh_slot0", pr);
    chk("rh issue_cnt slot0", issue_cnt, 32'd1);

    // Randomized traffic; a pair stays stable until consumed.
    do_reset(ind);
    pr = 1;
    cur = ind;
    for (int i = 0; i < 800; i++) begin
      if (pr || !cur.pv) begin
        cur = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom));
        cur.pv = ($urandom_range(0, 6) != 0);
        cur.v0 = ($urandom_range(0, 4) != 0);
        cur.v1 = ($urandom_range(0, 4) != 0);
      end
      if (m_hold) cur.pv = 1;
      cur.exr = ($urandom_range(0, 3) != 0);
      cur.fl  = ($urandom_range(0, 11) == 0);
      step(cur, "rand", pr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_issue_controller.md
Name: dual_issue_controller

Overview:
- Sits between the two decode_stage instances (slot 0 = instruction at pc, slot 1 = instruction at pc+4) and the execute lanes.
- Decides each cycle whether the decoded pair issues together, or is split when slot 1 depends on slot 0.
- Drives the accept handshake back to fetch/decode and keeps issue/split statistics.

Parameters:
- NUM_A_REGS, 32, architectural register count; register index width = $clog2(NUM_A_REGS).
- CNT_SIZE, 32, width of the statistics counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- pair_valid_i  in  1  decoded pair present
- valid0_i  in  1  slot 0 holds a real instruction
- valid1_i  in  1  slot 1 holds a real instruction
- rd0_i, rs10_i, rs20_i  in  $clog2(NUM_A_REGS) each  slot 0 register fields
- we0_i, use_rs10_i, use_rs20_i  in  1 each  slot 0 writes rd / reads rs1 / reads rs2
- rd1_i, rs11_i, rs21_i  in  $clog2(NUM_A_REGS) each  slot 1 register fields
- we1_i, use_rs11_i, use_rs21_i  in  1 each  slot 1 writes rd / reads rs1 / reads rs2
- ex_ready_i  in  1  execute lanes accept issue this cycle
- flush_i  in  1  discard the current pair (redirect)
- pair_ready_o  out  1  pair consumed this cycle; fetch advances pc by 8
- lane0_valid_o  out  1  lane 0 issues
- lane0_sel_o  out  1  decode slot driven onto lane 0 (0 = slot 0, 1 = slot 1)
- lane1_valid_o  out  1  lane 1 issues slot 1
- issue_cnt_o  out  CNT_SIZE  instructions issued
- split_cnt_o  out  CNT_SIZE  pairs split

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is synchronous and active-low.
- Reset state, held while rst_ni = 0:
  - state = PAIR.
  - All outputs 0, both counters 0.
- Hazard, computed combinationally:
  - dep = we0 & rd0 != 0 & ((use_rs11 & rs11 == rd0) | (use_rs21 & rs21 == rd0) | (we1 & rd1 == rd0)).
  - rd0 = 0 never creates a hazard.
- States: PAIR, HOLD1.
- PAIR with pair_valid_i & ex_ready_i & !flush_i:
  - valid0 & valid1 & !dep: lane0_valid = 1, sel = 0, lane1_valid = 1, pair_ready = 1; issue_cnt += 2; stay PAIR.
  - valid0 & valid1 & dep: lane0_valid = 1, sel = 0, lane1_valid = 0, pair_ready = 0; split_cnt += 1; issue_cnt += 1; go HOLD1.
  - Exactly one slot valid: issue it on lane 0 (sel = slot index), pair_ready = 1, issue_cnt += 1.
  - Neither valid: pair_ready = 1, nothing issues.
- HOLD1 with ex_ready_i & !flush_i: lane0_valid = 1, sel = 1, pair_ready = 1, issue_cnt += 1; go PAIR.
- ex_ready_i = 0: no issue, pair_ready = 0, state and counters hold. The pair inputs must stay stable while not consumed.
- flush_i = 1 has priority over everything:
  - No issue, pair_ready = 1 (pair dropped), state goes to PAIR, counters hold.
  - Applies in either state, including with ex_ready_i = 1.
- pair_valid_i = 0 in PAIR: all outputs 0.
- In HOLD1, pair_valid_i is required to be 1; the controller ignores it there.
- Outputs are combinational from state and inputs; state and counters are registered.
- Counters wrap modulo 2^CNT_SIZE.
- Reset asserted in HOLD1: the held instruction is lost, state goes to PAIR on the next edge.
- Latency: zero cycles from valid pair to issue. A split pair occupies 2 issue cycles.

Decomposition:
- riscv_pkg holds:
  - NUM_A_REGS, REG_IDX_SIZE and the ALU opcodes.
  - issue_state_t enum {PAIR, HOLD1}.
  - A slot_regs_t struct {rd, rs1, rs2, we, use_rs1, use_rs2}.
- Sub-module pair_hazard_check: combinational, takes two slot_regs_t, returns dep. It is reused by later forwarding logic.

Test Plan:
- Independent pair (add x1,x2,x3 ; add x4,x5,x6), ex_ready = 1 -> same cycle: lane0 (sel 0) and lane1 valid, pair_ready = 1; issue_cnt = 2.
- RAW pair (add x5,x1,x2 ; sub x7,x5,x3) -> cycle 1: lane0 only, pair_ready = 0, split_cnt = 1; cycle 2: lane0 sel = 1, pair_ready = 1; issue_cnt = 2.
- Destination x0 and WAW (rd0 = 0 read by slot 1 issues paired; rd0 = rd1 = 9 splits) -> 1 cycle and 2 cycles respectively.
- Backpressure: RAW pair with ex_ready = 0 for 3 cycles, then 1 -> no issue and counters stable for 3 cycles, then the split sequence runs normally.
- Flush in HOLD1 together with ex_ready = 1 -> no issue, pair_ready = 1, state returns to PAIR, issue_cnt unchanged.
- Reset (rst_ni = 0) sampled while in HOLD1 with counters = 5/2 -> next cycle all outputs 0, counters 0, state PAIR; valid1 = 0 pair then issues slot 0 alone.
